// File: rtl/cost_func_unit.sv
// Piecewise-linear sigmoid + squared-error cost unit sequencing nominal/perturbed passes.
// Optional error counter is built when COST_ERR_COUNT_EN is defined.
module cost_func_unit #(
  parameter int QN           = 6,
  parameter int QM           = 11,
  parameter int BITWIDTH     = QN + QM + 1,
  parameter int PULSE_CYCLES = 2,
  parameter int ERR_CNT_W    = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 dataReadyP,
  input  logic [BITWIDTH-1:0]  networkOutput,
  input  logic                 modelOutput,
  input  logic                 trainingReady,
  input  logic                 clrCount,
  output logic [BITWIDTH-1:0]  costFunc,
  output logic                 newCostFunc,
  output logic                 prediction,
  output logic                 predValid,
  output logic [ERR_CNT_W-1:0] errCount,
  output logic                 busy,
  output logic [2:0]           state_dbg
);

  typedef enum logic [2:0] {IDLE, SIGM, SQR, PULSE, WAIT_TRAIN} state_t;

  localparam int PCW = $clog2(PULSE_CYCLES + 1);
  localparam logic [BITWIDTH-1:0] A_MAX  = {1'b0, {(BITWIDTH-1){1'b1}}};
  localparam logic [BITWIDTH-1:0] A_MIN  = {1'b1, {(BITWIDTH-1){1'b0}}};
  localparam logic [BITWIDTH-1:0] A_FIVE = BITWIDTH'(5 * 2**QM);
  localparam logic [BITWIDTH-1:0] A_BRK  = BITWIDTH'(19 * 2**(QM-3));
  localparam logic [BITWIDTH-1:0] A_ONE  = BITWIDTH'(2**QM);
  localparam logic [BITWIDTH-1:0] C_HI   = BITWIDTH'(27 * 2**(QM-5));
  localparam logic [BITWIDTH-1:0] C_MID  = BITWIDTH'(5 * 2**(QM-3));
  localparam logic [BITWIDTH-1:0] C_LO   = BITWIDTH'(2**(QM-1));
  localparam logic [QM:0]         S_ONE  = (QM+1)'(2**QM);
  localparam logic [QM:0]         S_HALF = (QM+1)'(2**(QM-1));

  state_t               state, state_nxt;
  logic                 pass_q, pass_nxt;
  logic                 dr_q, dr_q2;
  logic [PCW-1:0]       pcnt_q;
  logic [BITWIDTH-1:0]  x_q;
  logic [QM:0]          s_q;
  logic                 m_q;
  logic                 start;

  logic [BITWIDTH-1:0]  a;
  logic [QM:0]          y, s;
  logic [QM+1:0]        target, e, mag;
  logic [2*QM+3:0]      sq;
  logic                 pred_n;

  // Start uses only registered copies of dataReadyP, so no combinational path to state.
  assign start = (state == IDLE) && dr_q && !dr_q2;

  always_comb begin
    a = x_q;
    if (x_q[BITWIDTH-1]) a = (x_q == A_MIN) ? A_MAX : -x_q;
    if (a >= A_FIVE)     y = S_ONE;
    else if (a >= A_BRK) y = (QM+1)'((a >> 5) + C_HI);
    else if (a >= A_ONE) y = (QM+1)'((a >> 3) + C_MID);
    else                 y = (QM+1)'((a >> 2) + C_LO);
    s = x_q[BITWIDTH-1] ? S_ONE - y : y;
  end

  always_comb begin
    target = m_q ? {1'b0, S_ONE} : '0;
    e      = target - {1'b0, s_q};
    mag    = e[QM+1] ? -e : e;
    sq     = (2*QM+4)'(mag) * (2*QM+4)'(mag);
    pred_n = (s_q >= S_HALF);
  end

  always_comb begin
    state_nxt = state;
    pass_nxt  = pass_q;
    case (state)
      IDLE:       if (start) state_nxt = SIGM;
      SIGM:       state_nxt = SQR;
      SQR:        state_nxt = PULSE;
      PULSE: begin
        if (pcnt_q == PCW'(PULSE_CYCLES - 1)) begin
          if (!pass_q) begin
            state_nxt = IDLE;
            pass_nxt  = 1'b1;
          end else begin
            state_nxt = WAIT_TRAIN;
          end
        end
      end
      WAIT_TRAIN: begin
        if (trainingReady) begin
          state_nxt = IDLE;
          pass_nxt  = 1'b0;
        end
      end
      default:    state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      pass_q     <= 1'b0;
      dr_q       <= 1'b0;
      dr_q2      <= 1'b0;
      pcnt_q     <= '0;
      x_q        <= '0;
      s_q        <= '0;
      m_q        <= 1'b0;
      costFunc   <= '0;
      prediction <= 1'b0;
      predValid  <= 1'b0;
    end else begin
      state     <= state_nxt;
      pass_q    <= pass_nxt;
      dr_q      <= dataReadyP;
      dr_q2     <= dr_q;
      pcnt_q    <= (state == PULSE) ? pcnt_q + PCW'(1) : '0;
      predValid <= 1'b0;
      if (start) x_q <= networkOutput;
      if (state == SIGM) begin
        s_q <= s;
        m_q <= modelOutput;
      end
      if (state == SQR) begin
        costFunc <= BITWIDTH'(sq >> QM);
        if (!pass_q) begin
          prediction <= pred_n;
          predValid  <= 1'b1;
        end
      end
    end
  end

`ifdef COST_ERR_COUNT_EN
  logic [ERR_CNT_W-1:0] err_q;

  // Clear has priority over a same-cycle increment.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)                  err_q <= '0;
    else if (clrCount)           err_q <= '0;
    else if (state == SQR && !pass_q && (pred_n != m_q) && !(&err_q))
                                 err_q <= err_q + ERR_CNT_W'(1);
  end

  assign errCount = err_q;
`else
  logic unused_clr;
  assign unused_clr = clrCount;
  assign errCount   = '0;
`endif

  assign newCostFunc = (state == PULSE);
  assign busy        = (state != IDLE);
  assign state_dbg   = state;

endmodule
